cond_flag_gen: RTL and testbench
================================

Name: cond_flag_gen

Overview:
Multi-cycle, digit-serial flag generator for the set-on-condition instructions (SEQ, SLT, SLE, SCO). It is the producer side of the condition-set path.
- Takes two 16-bit register operands and the 2-bit condition select.
- Computes the compare/add result over several cycles.
- Delivers zero, cout and alu_out_msb flags with a start/done handshake.
- Sits between the register-read stage and the condition-set logic in the execute stage.

Parameters:
DIGIT_W, 4, bits processed per cycle. Legal values: 1, 2, 4, 8, 16. Fixes NSTEP = 16/DIGIT_W.

Ports:
clk  input  1  clock, rising-edge.
rst  input  1  synchronous, active-high reset.
start  input  1  request; sampled only when ready=1.
instr  input  2  condition select: 00 SEQ, 01 SLT, 10 SLE, 11 SCO.
a  input  16  operand Rs.
b  input  16  operand Rt.
ready  output  1  high in IDLE and DONE; start accepted.
done  output  1  one-cycle pulse; flags valid.
zero  output  1  result == 0.
cout  output  1  carry out of bit 15.
alu_out_msb  output  1  sign indicator, defined below.

Behaviour:
- Reset (synchronous, active-high, any state including mid-RUN):
  - state=IDLE, counter=0, done=0.
  - zero=0, cout=0, alu_out_msb=0, ready=1 after the edge.
- States: IDLE, RUN, DONE.
  - IDLE/DONE + start=1: latch a, b, instr; go to RUN; digit counter=0; carry-in per operation.
  - RUN: one DIGIT_W-bit digit per cycle, LSB first. Counter increments. After digit NSTEP-1, go to DONE.
  - DONE: done=1 for exactly this cycle. With no start, go to IDLE next edge. With start, go to RUN (back-to-back).
  - start while RUN is ignored; latched operands are unaffected.
- Latency: done is high NSTEP cycles after the edge that sampled start (DIGIT_W=4 gives 4 cycles). Throughput is one op per NSTEP cycles.
- Operation by instr:
  - 00, 01: R = a + ~b + 1 (a - b).
  - 10: R = b + ~a + 1 (b - a).
  - 11: R = a + b, carry-in 0.
- Flag computation:
  - zero = (R[15:0] == 0), accumulated as an OR of digits across steps.
  - cout = carry out of bit 15.
  - alu_out_msb = R[15] XOR V, where V = signed overflow from the carries into and out of bit 15. This is the true signed-negative result, so SLT and SLE are correct at extremes.
- Flags update only on the transition into DONE. They hold until the next completed op or reset; partial results are never visible.
- 16-bit wrap: sums modulo 2^16; carry is exposed only on cout.

Optional Feature:
Macro COND_FLAG_SET_OUT_EN.
- Defined: adds output port set [15:0], registered at DONE and held like the flags.
  - set = {15'b0, s}, where s is: zero (00), alu_out_msb (01), ~alu_out_msb (10), cout (11).
  - Reset value 16'h0000.
- Not defined: port absent; flags are the only result.

Test Plan:
- SEQ: rst 2 cycles, then start, instr=00, a=16'h0005, b=16'h0005 -> done after 4 cycles; zero=1, alu_out_msb=0 (set=16'h0001 with macro).
- SLT overflow: instr=01, a=16'h8000, b=16'h0001 -> alu_out_msb=1, zero=0, even though raw R=16'h7FFF (set=1). Same op with a=16'h0001, b=16'h8000 -> alu_out_msb=0.
- SLE equal: instr=10, a=16'h0003, b=16'h0003 -> zero=1, alu_out_msb=0 (set=1). Then a=16'h0004, b=16'h0003 -> alu_out_msb=1 (set=0).
- SCO wrap: instr=11, a=16'hFFFF, b=16'h0001 -> cout=1, zero=1. Then a=16'h7FFF, b=16'h0001 -> cout=0, zero=0.
- Handshake:
  - start pulsed in RUN with different operands -> ignored; result matches the first operands.
  - start asserted in DONE cycle -> next done exactly 4 cycles later.
- Reset mid-op: rst=1 on the 2nd RUN cycle -> next edge: done=0, all flags 0, ready=1. No done pulse follows.

Source files
------------

// File: rtl/cond_flag_gen.sv
`default_nettype none
// =============================================================================
// cond_flag_gen : digit-serial flag generator for SEQ/SLT/SLE/SCO
// Optional macro COND_FLAG_SET_OUT_EN adds the registered set[15:0] output.
// Revision: 1.0
// =============================================================================
module cond_flag_gen #(
  parameter int DIGIT_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  instr,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        ready,
  output logic        done,
  output logic        zero,
  output logic        cout,
  output logic        alu_out_msb
`ifdef COND_FLAG_SET_OUT_EN
  ,
  output logic [15:0] set
`endif
);

  localparam int NSTEP = 16 / DIGIT_W;
  localparam int CNT_W = (NSTEP > 1) ? $clog2(NSTEP) : 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(NSTEP - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [15:0]      r_x;
  logic [15:0]      r_y;
  logic             r_carry;
  logic             r_nz;
  logic [1:0]       r_instr;

  logic [DIGIT_W:0] w_sum;
  logic             w_r_msb;
  logic             w_c_out;
  logic             w_c_msb_in;
  logic             w_msb;
  logic             w_zero;
  logic             w_last;

  // Carry into the digit MSB is recovered as x^y^sum, so V works for any DIGIT_W.
  always_comb begin
    w_sum      = {1'b0, r_x[DIGIT_W-1:0]} + {1'b0, r_y[DIGIT_W-1:0]}
               + {{DIGIT_W{1'b0}}, r_carry};
    w_c_out    = w_sum[DIGIT_W];
    w_r_msb    = w_sum[DIGIT_W-1];
    w_c_msb_in = r_x[DIGIT_W-1] ^ r_y[DIGIT_W-1] ^ w_r_msb;
    w_msb      = w_r_msb ^ (w_c_msb_in ^ w_c_out);
    w_zero     = ~(r_nz | (|w_sum[DIGIT_W-1:0]));
    w_last     = (r_cnt == C_LAST);
  end

  assign ready = (r_state != S_RUN);

`ifdef COND_FLAG_SET_OUT_EN
  logic w_set_bit;
  always_comb begin
    w_set_bit = 1'b0;
    case (r_instr)
      2'b00:   w_set_bit = w_zero;
      2'b01:   w_set_bit = w_msb;
      2'b10:   w_set_bit = ~w_msb;
      default: w_set_bit = w_c_out;
    endcase
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_carry     <= 1'b0;
      r_nz        <= 1'b0;
      r_instr     <= '0;
      done        <= 1'b0;
      zero        <= 1'b0;
      cout        <= 1'b0;
      alu_out_msb <= 1'b0;
`ifdef COND_FLAG_SET_OUT_EN
      set         <= 16'h0000;
`endif
    end else begin
      done <= 1'b0;
      case (r_state)
        S_RUN: begin
          r_x     <= r_x >> DIGIT_W;
          r_y     <= r_y >> DIGIT_W;
          r_carry <= w_c_out;
          r_nz    <= ~w_zero;
          r_cnt   <= r_cnt + 1'b1;
          if (w_last) begin
            r_state     <= S_DONE;
            done        <= 1'b1;
            zero        <= w_zero;
            cout        <= w_c_out;
            alu_out_msb <= w_msb;
`ifdef COND_FLAG_SET_OUT_EN
            set         <= {15'b0, w_set_bit};
`endif
          end
        end
        default: begin
          if (start) begin
            r_state <= S_RUN;
            r_cnt   <= '0;
            r_nz    <= 1'b0;
            r_instr <= instr;
            case (instr)
              2'b10: begin
                r_x     <= b;
                r_y     <= ~a;
                r_carry <= 1'b1;
              end
              2'b11: begin
                r_x     <= a;
                r_y     <= b;
                r_carry <= 1'b0;
              end
              default: begin
                r_x     <= a;
                r_y     <= ~b;
                r_carry <= 1'b1;
              end
            endcase
          end else begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cond_flag_gen.sv
`default_nettype none
// tb_cond_flag_gen : table-driven vectors with a scoreboard queue, plus
// handshake and mid-operation reset sequences.
module tb_cond_flag_gen;

  localparam int NSTEP = 4;

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  instr = 2'b00;
  logic [15:0] a     = 16'h0000;
  logic [15:0] b     = 16'h0000;
  logic        ready, done, zero, cout, alu_out_msb;
`ifdef COND_FLAG_SET_OUT_EN
  logic [15:0] set;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [1:0]  instr;
    logic [15:0] a;
    logic [15:0] b;
    logic        z;
    logic        c;
    logic        m;
  } vec_t;

  typedef struct {
    logic        z;
    logic        c;
    logic        m;
    logic [15:0] s;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[12];

  cond_flag_gen #(.DIGIT_W(4)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .instr(instr),
    .a(a),
    .b(b),
    .ready(ready),
    .done(done),
    .zero(zero),
    .cout(cout),
    .alu_out_msb(alu_out_msb)
`ifdef COND_FLAG_SET_OUT_EN
    ,
    .set(set)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] exp_set(input logic [1:0] i, input logic z,
                                          input logic c, input logic m);
    logic s;
    case (i)
      2'b00:   s = z;
      2'b01:   s = m;
      2'b10:   s = ~m;
      default: s = c;
    endcase
    return {15'b0, s};
  endfunction

  task automatic check1(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst && done) begin
      if (sb.size() == 0) begin
        check1("done_without_op", {15'b0, done}, 16'h0000);
      end else begin
        e = sb.pop_front();
        check1("flags_zcm", {13'b0, zero, cout, alu_out_msb}, {13'b0, e.z, e.c, e.m});
        check1("ready_in_done", {15'b0, ready}, 16'h0001);
`ifdef COND_FLAG_SET_OUT_EN
        check1("set_out", set, e.s);
`endif
      end
    end
  end

  // Called just after a negedge; returns one negedge later with start dropped.
  task automatic issue(input logic [1:0] i, input logic [15:0] aa, input logic [15:0] bb,
                       input logic z, input logic c, input logic m);
    exp_t e;
    check1("ready_before_start", {15'b0, ready}, 16'h0001);
    start = 1'b1;
    instr = i;
    a     = aa;
    b     = bb;
    e.z = z;
    e.c = c;
    e.m = m;
    e.s = exp_set(i, z, c, m);
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    a     = ~aa;
    b     = ~bb;
    instr = ~i;
  endtask

  task automatic wait_done(output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!done && k < 50);
    if (!done) check1("done_timeout", {15'b0, done}, 16'h0001);
  endtask

  initial begin
    int k;
    int seen;

    tbl[0]  = '{2'b00, 16'h0005, 16'h0005, 1'b1, 1'b1, 1'b0};
    tbl[1]  = '{2'b01, 16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1};
    tbl[2]  = '{2'b01, 16'h0001, 16'h8000, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{2'b10, 16'h0003, 16'h0003, 1'b1, 1'b1, 1'b0};
    tbl[4]  = '{2'b10, 16'h0004, 16'h0003, 1'b0, 1'b0, 1'b1};
    tbl[5]  = '{2'b11, 16'hFFFF, 16'h0001, 1'b1, 1'b1, 1'b0};
    tbl[6]  = '{2'b11, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{2'b00, 16'h1234, 16'h1235, 1'b0, 1'b0, 1'b1};
    tbl[8]  = '{2'b11, 16'h8000, 16'h8000, 1'b1, 1'b1, 1'b1};
    tbl[9]  = '{2'b10, 16'h8000, 16'h7FFF, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{2'b01, 16'h0100, 16'h0000, 1'b0, 1'b1, 1'b0};
    tbl[11] = '{2'b11, 16'h0F00, 16'h0100, 1'b0, 1'b0, 1'b0};

    rst = 1'b1;
    repeat (2) @(negedge clk);
    check1("rst_done", {15'b0, done}, 16'h0000);
    check1("rst_flags", {13'b0, zero, cout, alu_out_msb}, 16'h0000);
    check1("rst_ready", {15'b0, ready}, 16'h0001);
`ifdef COND_FLAG_SET_OUT_EN
    check1("rst_set", set, 16'h0000);
`endif
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      issue(tbl[i].instr, tbl[i].a, tbl[i].b, tbl[i].z, tbl[i].c, tbl[i].m);
      wait_done(k);
      check1("latency", 16'(k), 16'(NSTEP));
      if (i % 3 == 2) begin
        @(negedge clk);
        check1("idle_done_low", {15'b0, done}, 16'h0000);
      end
    end

    // start pulsed during RUN must be ignored
    @(negedge clk);
    issue(2'b01, 16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    start = 1'b1;
    instr = 2'b11;
    a     = 16'hFFFF;
    b     = 16'h0001;
    @(negedge clk);
    start = 1'b0;
    wait_done(k);
    check1("run_start_ignored_latency", 16'(k), 16'(NSTEP - 2));
    @(negedge clk);
    check1("no_extra_op", {15'b0, done}, 16'h0000);

    // start during the DONE cycle: next op back-to-back
    issue(2'b10, 16'h0004, 16'h0003, 1'b0, 1'b0, 1'b1);
    wait_done(k);
    issue(2'b11, 16'hFFFF, 16'h0001, 1'b1, 1'b1, 1'b0);
    wait_done(k);
    check1("b2b_latency", 16'(k), 16'(NSTEP));
    @(negedge clk);
    check1("idle_ready", {15'b0, ready}, 16'h0001);

    // reset on the second RUN cycle
    issue(2'b00, 16'h0005, 16'h0005, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check1("midrst_done", {15'b0, done}, 16'h0000);
    check1("midrst_flags", {13'b0, zero, cout, alu_out_msb}, 16'h0000);
    check1("midrst_ready", {15'b0, ready}, 16'h0001);
`ifdef COND_FLAG_SET_OUT_EN
    check1("midrst_set", set, 16'h0000);
`endif
    sb.delete();
    rst  = 1'b0;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) seen++;
    end
    check1("midrst_no_done", 16'(seen), 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
